// File: rtl/sprite_pos_ctrl.sv
// Frame-synchronous sprite position controller: latches direction requests during a frame
// and applies one clamped step per due frame boundary through a single shared adder.
module sprite_pos_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned SPRITE_W  = 16,
  parameter int unsigned SPRITE_H  = 11,
  parameter int unsigned START_ROW = 460,
  parameter int unsigned START_COL = 312,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 2
) (
  input  logic        vga_clk_i,
  input  logic        vga_rst_i,
  input  logic        vert_sync_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  output logic [11:0] btn_row,
  output logic [11:0] btn_col,
  output logic        moved_o
);

  localparam logic [12:0] ROW_MAX  = 13'(V_ACTIVE - SPRITE_H);
  localparam logic [12:0] COL_MAX  = 13'(H_ACTIVE - SPRITE_W);
  localparam logic [12:0] STEP_V   = 13'(STEP);
  localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [11:0] ROW_INIT = 12'(START_ROW);
  localparam logic [11:0] COL_INIT = 12'(START_COL);

  typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

  state_t      state;
  logic        vs_q;
  logic        tick;
  logic [3:0]  div;
  logic [3:0]  btns;   // {up, down, left, right}
  logic [3:0]  req;
  logic [3:0]  pend;
  logic        chg;

  logic [12:0] cur;
  logic [12:0] lim;
  logic [12:0] sum;
  logic [12:0] nxt;
  logic        inc;
  logic        dec;

  assign btns = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
  assign tick = vs_q & ~vert_sync_i;

  // Shared step adder: operand and request pair selected by the current FSM state.
  always_comb begin
    cur = {1'b0, btn_row};
    lim = ROW_MAX;
    inc = pend[2];
    dec = pend[3];
    if (state == COL) begin
      cur = {1'b0, btn_col};
      lim = COL_MAX;
      inc = pend[0];
      dec = pend[1];
    end
    sum = cur + STEP_V;
    nxt = cur;
    if (inc && !dec) begin
      nxt = (sum > lim) ? lim : sum;
    end else if (dec && !inc) begin
      nxt = (cur < STEP_V) ? '0 : cur - STEP_V;
    end
  end

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) begin
      state   <= IDLE;
      vs_q    <= 1'b0;
      div     <= '0;
      req     <= '0;
      pend    <= '0;
      chg     <= 1'b0;
      btn_row <= ROW_INIT;
      btn_col <= COL_INIT;
      moved_o <= 1'b0;
    end else begin
      vs_q    <= vert_sync_i;
      moved_o <= 1'b0;
      req     <= req | btns;
      case (state)
        IDLE: begin
          if (tick) begin
            if (div == DIV_LAST) begin
              div   <= '0;
              pend  <= req | btns;
              req   <= '0;  // same-cycle presses land in pend, not req
              state <= ROW;
            end else begin
              div <= div + 4'd1;
            end
          end
        end
        ROW: begin
          btn_row <= nxt[11:0];
          chg     <= (nxt != {1'b0, btn_row});
          state   <= COL;
        end
        COL: begin
          btn_col <= nxt[11:0];
          moved_o <= chg | (nxt != {1'b0, btn_col});
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Scoreboard bench for sprite_pos_ctrl: default instance plus a STEP=1, FRAME_DIV=1
// instance used for the left-edge clamp.
module tb_sprite_pos_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs  = 1'b0;
  logic        vs2 = 1'b1;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        left2 = 1'b0;
  logic [11:0] row1, col1, row2, col2;
  logic        mv1, mv2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int row;
    int col;
    int moved;
  } exp_t;
  exp_t sb[$];

  int prev_col [2];

  always #5 clk = ~clk;

  sprite_pos_ctrl u_dut (
    .vga_clk_i  (clk),
    .vga_rst_i  (rst),
    .vert_sync_i(vs),
    .btn_up_i   (up),
    .btn_down_i (down),
    .btn_left_i (left),
    .btn_right_i(right),
    .btn_row    (row1),
    .btn_col    (col1),
    .moved_o    (mv1)
  );

  sprite_pos_ctrl #(
    .STEP     (1),
    .FRAME_DIV(1),
    .START_COL(3)
  ) u_dut2 (
    .vga_clk_i  (clk),
    .vga_rst_i  (rst),
    .vert_sync_i(vs2),
    .btn_up_i   (1'b0),
    .btn_down_i (1'b0),
    .btn_left_i (left2),
    .btn_right_i(1'b0),
    .btn_row    (row2),
    .btn_col    (col2),
    .moved_o    (mv2)
  );

  task automatic check(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_row(input int which);
    return (which == 0) ? int'(row1) : int'(row2);
  endfunction

  function automatic int get_col(input int which);
    return (which == 0) ? int'(col1) : int'(col2);
  endfunction

  function automatic int get_mv(input int which);
    return (which == 0) ? int'(mv1) : int'(mv2);
  endfunction

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    step();
    up = u; down = d | down; left = l; right = r;
    step();
    up = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  // One sync falling edge on the chosen instance; E+2 shows the new row, E+3 the new column.
  task automatic frame(input string tag, input int which, input int er, input int ec, input int em);
    exp_t e;
    step();
    if (which == 0) vs = 1'b0; else vs2 = 1'b0;
    sb.push_back('{er, ec, em});
    step();
    check({tag, ":mv_e1"}, get_mv(which), 0);
    step();
    check({tag, ":row_e2"}, get_row(which), er);
    check({tag, ":col_e2"}, get_col(which), prev_col[which]);
    check({tag, ":mv_e2"}, get_mv(which), 0);
    step();
    e = sb.pop_front();
    check({tag, ":row_e3"}, get_row(which), e.row);
    check({tag, ":col_e3"}, get_col(which), e.col);
    check({tag, ":mv_e3"}, get_mv(which), e.moved);
    step();
    check({tag, ":mv_e4"}, get_mv(which), 0);
    check({tag, ":col_e4"}, get_col(which), e.col);
    if (which == 0) vs = 1'b1; else vs2 = 1'b1;
    prev_col[which] = ec;
    repeat (3) step();
  endtask

  initial begin
    exp_t e;
    int sat_rows [6] = '{462, 464, 466, 468, 469, 469};
    int sat_mv   [6] = '{1, 1, 1, 1, 1, 0};
    int clamp_col[4] = '{2, 1, 0, 0};
    int clamp_mv [4] = '{1, 1, 1, 0};

    prev_col[0] = 312;
    prev_col[1] = 3;

    // reset held for 3 cycles with sync low, then sync kept low: no update allowed
    repeat (3) step();
    rst = 1'b0;
    check("rst_row", int'(row1), 460);
    check("rst_col", int'(col1), 312);
    check("rst_mv", int'(mv1), 0);
    check("rst2_col", int'(col2), 3);
    repeat (5) begin
      step();
      check("hold_row", int'(row1), 460);
      check("hold_col", int'(col1), 312);
      check("hold_mv", int'(mv1), 0);
    end
    vs = 1'b1;
    repeat (3) step();

    // single-cycle right press, applied only on the second frame edge
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    frame("right_f1", 0, 460, 312, 0);
    frame("right_f2", 0, 460, 314, 1);

    // held down: saturates at ROW_MAX = 469
    down = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame("down_skip", 0, sat_rows[i] - ((i == 0) ? 2 : ((sat_rows[i] == sat_rows[i-1]) ? 0 : sat_rows[i] - sat_rows[i-1])), 314, 0);
      frame("down_upd", 0, sat_rows[i], 314, sat_mv[i]);
    end
    down = 1'b0;
    // request captured after the last snapshot drains as a clamped no-op
    frame("drain_skip", 0, 469, 314, 0);
    frame("drain_upd", 0, 469, 314, 0);

    // left+right cancel, up moves row by one step
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    frame("opp_skip", 0, 469, 314, 0);
    frame("opp_upd", 0, 467, 314, 1);

    // reset during ROW abandons a pending right move
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    frame("rrow_skip", 0, 467, 314, 0);
    step();
    vs = 1'b0;
    sb.push_back('{460, 312, 0});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = sb.pop_front();
    check("rrow_row", int'(row1), e.row);
    check("rrow_col", int'(col1), e.col);
    check("rrow_mv", int'(mv1), e.moved);
    step();
    check("rrow_row2", int'(row1), 460);
    check("rrow_col2", int'(col1), 312);
    check("rrow_mv2", int'(mv1), 0);
    vs = 1'b1;
    prev_col[0] = 312;
    prev_col[1] = 3;
    repeat (3) step();
    frame("post_rst_f1", 0, 460, 312, 0);
    frame("post_rst_f2", 0, 460, 312, 0);

    // STEP=1 instance: left walks 3 -> 2 -> 1 -> 0 -> 0
    left2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame("clamp_l", 1, 460, clamp_col[i], clamp_mv[i]);
    end
    left2 = 1'b0;

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // moved_o must never be high on two consecutive cycles
  logic mv1_q = 1'b0;
  always @(negedge clk) begin
    if (mv1 && mv1_q) begin
      bad++;
      $display("FAIL moved_width: got 2 consecutive cycles expected 1");
    end
    mv1_q <= mv1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
